// File: rtl/writeback_pkg.sv
// Shared definitions for the memory-to-writeback bundle and the writeback FSM.
// The memory stage builds W_in with pack_bundle so both ends agree on field positions.
package writeback_pkg;

    localparam int W_WIDTH        = 39;
    localparam int DATA_W         = 16;
    localparam int REG_W          = 4;

    localparam int ALU_LSB        = 23;
    localparam int MEM_LSB        = 7;
    localparam int WR_REG_LSB     = 3;
    localparam int HALT_BIT       = 2;
    localparam int REG_WRITE_BIT  = 1;
    localparam int MEM_TO_REG_BIT = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

    function automatic logic [W_WIDTH-1:0] pack_bundle(
        input logic [DATA_W-1:0] alu_result,
        input logic [DATA_W-1:0] mem_data,
        input logic [REG_W-1:0]  wr_reg,
        input logic              halt,
        input logic              reg_write,
        input logic              mem_to_reg
    );
        logic [W_WIDTH-1:0] bundle;
        bundle                          = '0;
        bundle[ALU_LSB +: DATA_W]       = alu_result;
        bundle[MEM_LSB +: DATA_W]       = mem_data;
        bundle[WR_REG_LSB +: REG_W]     = wr_reg;
        bundle[HALT_BIT]                = halt;
        bundle[REG_WRITE_BIT]           = reg_write;
        bundle[MEM_TO_REG_BIT]          = mem_to_reg;
        return bundle;
    endfunction

endpackage

// File: rtl/writeback_sat_counter16.sv
// 16-bit counter that sticks at all-ones instead of wrapping; synchronous reset.
module sat_counter16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/writeback.sv
// Writeback stage: M/W pipeline register, register-file write port, write-before-read
// bypass, halt FSM and retired-instruction counter.
module writeback
    import writeback_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [W_WIDTH-1:0] W_in,
    input  logic               W_valid,
    input  logic [REG_W-1:0]   rd_reg1,
    input  logic [REG_W-1:0]   rd_reg2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    output logic               rf_wr_en,
    output logic [REG_W-1:0]   rf_wr_reg,
    output logic [DATA_W-1:0]  rf_wr_data,
    output logic [DATA_W-1:0]  byp_rdata1,
    output logic [DATA_W-1:0]  byp_rdata2,
    output logic               halted,
    output logic [DATA_W-1:0]  retired
);

    logic [W_WIDTH-1:0] entry_q;
    logic               valid_q;
    wb_state_e          state_q;
    wb_state_e          state_d;

    logic               entryHalt;
    logic               entryRegWrite;
    logic               entryMemToReg;
    logic               inRun;
    logic               bypEn;

    assign entryHalt     = entry_q[HALT_BIT];
    assign entryRegWrite = entry_q[REG_WRITE_BIT];
    assign entryMemToReg = entry_q[MEM_TO_REG_BIT];
    assign inRun         = (state_q == RUN);

    // Once halted the register freezes so the stalled pipeline cannot retire anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
            valid_q <= 1'b0;
            state_q <= RUN;
        end else begin
            state_q <= state_d;
            if (inRun) begin
                entry_q <= W_in;
                valid_q <= W_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (inRun && valid_q && entryHalt) begin
            state_d = HALTED;
        end
    end

    assign rf_wr_reg  = entry_q[WR_REG_LSB +: REG_W];
    assign rf_wr_data = entryMemToReg ? entry_q[MEM_LSB +: DATA_W]
                                      : entry_q[ALU_LSB +: DATA_W];
    assign rf_wr_en   = valid_q & entryRegWrite & ~entryHalt
                      & (rf_wr_reg != '0) & inRun;

    // Bypass is masked during reset so raw register-file data always passes through.
    assign bypEn      = rf_wr_en & ~rst;
    assign byp_rdata1 = (bypEn && (rd_reg1 == rf_wr_reg)) ? rf_wr_data : rf_rdata1;
    assign byp_rdata2 = (bypEn && (rd_reg2 == rf_wr_reg)) ? rf_wr_data : rf_rdata2;

    assign halted     = (state_q == HALTED);

    sat_counter16 u_retired (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (inRun & valid_q),
        .count_o (retired)
    );

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: each driven entry pushes its expected post-edge
// outputs, which are popped and compared one cycle later.
module tb_writeback;

    logic        clk;
    logic        rst;
    logic [38:0] W_in;
    logic        W_valid;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_reg;
    logic [15:0] rf_wr_data;
    logic [15:0] byp_rdata1;
    logic [15:0] byp_rdata2;
    logic        halted;
    logic [15:0] retired;

    typedef struct {
        logic        en;
        logic [3:0]  wreg;
        logic [15:0] wdata;
        logic [15:0] b1;
        logic [15:0] b2;
        logic        hlt;
        logic [15:0] ret;
    } exp_t;

    exp_t sbQ[$];

    int checkCount = 0;
    int errorCount = 0;

    logic [38:0] mHeld;
    logic        mValid;
    logic        mHalted;
    int          mRetired;

    writeback dut (
        .clk        (clk),
        .rst        (rst),
        .W_in       (W_in),
        .W_valid    (W_valid),
        .rd_reg1    (rd_reg1),
        .rd_reg2    (rd_reg2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_reg  (rf_wr_reg),
        .rf_wr_data (rf_wr_data),
        .byp_rdata1 (byp_rdata1),
        .byp_rdata2 (byp_rdata2),
        .halted     (halted),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model across the coming edge
    // and push the outputs expected right after that edge.
    task automatic applyStimulus(input logic doRst, input logic v,
                                 input logic [15:0] alu, input logic [15:0] mem,
                                 input logic [3:0] wr, input logic hlt,
                                 input logic rw, input logic m2r,
                                 input logic [3:0] r1, input logic [3:0] r2,
                                 input logic [15:0] d1, input logic [15:0] d2);
        exp_t e;
        logic [15:0] hAlu, hMem;
        logic [3:0]  hWr;
        logic        hHalt, hRw, hM2r;
        rst       = doRst;
        W_in      = {alu, mem, wr, hlt, rw, m2r};
        W_valid   = v;
        rd_reg1   = r1;
        rd_reg2   = r2;
        rf_rdata1 = d1;
        rf_rdata2 = d2;
        if (doRst) begin
            mHeld = '0; mValid = 1'b0; mHalted = 1'b0; mRetired = 0;
        end else if (!mHalted) begin
            if (mValid && mRetired < 65535) mRetired++;
            mHalted = mValid & mHeld[2];
            mHeld   = {alu, mem, wr, hlt, rw, m2r};
            mValid  = v;
        end
        hAlu  = mHeld[38:23];
        hMem  = mHeld[22:7];
        hWr   = mHeld[6:3];
        hHalt = mHeld[2];
        hRw   = mHeld[1];
        hM2r  = mHeld[0];
        e.en    = !mHalted && mValid && hRw && !hHalt && (hWr != 4'd0);
        e.wreg  = hWr;
        e.wdata = hM2r ? hMem : hAlu;
        e.b1    = (e.en && !doRst && r1 == hWr) ? e.wdata : d1;
        e.b2    = (e.en && !doRst && r2 == hWr) ? e.wdata : d2;
        e.hlt   = mHalted;
        e.ret   = mRetired[15:0];
        sbQ.push_back(e);
    endtask

    task automatic stepAndCompare(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbQ.size() == 0) begin
            checkOutput({tag, ".sbEmpty"}, 32'd0, 32'd1);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, ".en"},      32'(rf_wr_en),   32'(e.en));
            checkOutput({tag, ".reg"},     32'(rf_wr_reg),  32'(e.wreg));
            checkOutput({tag, ".data"},    32'(rf_wr_data), 32'(e.wdata));
            checkOutput({tag, ".byp1"},    32'(byp_rdata1), 32'(e.b1));
            checkOutput({tag, ".byp2"},    32'(byp_rdata2), 32'(e.b2));
            checkOutput({tag, ".halted"},  32'(halted),     32'(e.hlt));
            checkOutput({tag, ".retired"}, 32'(retired),    32'(e.ret));
        end
    endtask

    task automatic cycle(input string tag, input logic doRst, input logic v,
                         input logic [15:0] alu, input logic [15:0] mem,
                         input logic [3:0] wr, input logic hlt, input logic rw,
                         input logic m2r, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [15:0] d1, input logic [15:0] d2);
        applyStimulus(doRst, v, alu, mem, wr, hlt, rw, m2r, r1, r2, d1, d2);
        stepAndCompare(tag);
    endtask

    initial begin
        mHeld = '0; mValid = 1'b0; mHalted = 1'b0; mRetired = 0;
        rst = 1'b1; W_in = '0; W_valid = 1'b0;
        rd_reg1 = '0; rd_reg2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
        #1;

        // Reset with a live write entry on the inputs, which must be ignored.
        cycle("reset", 1'b1, 1'b1, 16'h1111, 16'h2222, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 16'h0A0A, 16'h0B0B);

        cycle("aluWrite",  1'b0, 1'b1, 16'h1234, 16'h9999, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 4'd2, 16'h0000, 16'h4444);
        cycle("bubble",    1'b0, 1'b0, 16'hDEAD, 16'hDEAD, 4'd4, 1'b1, 1'b1, 1'b1, 4'd4, 4'd4, 16'h1357, 16'h2468);
        cycle("loadByp",   1'b0, 1'b1, 16'h0010, 16'hBEEF, 4'd5, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 16'h0000, 16'h7777);
        cycle("loadNoByp", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 4'd5, 1'b0, 1'b1, 1'b1, 4'd6, 4'd5, 16'h5555, 16'h0000);
        cycle("r0Write",   1'b0, 1'b1, 16'hCAFE, 16'hF00D, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 16'hAAAA, 16'hBBBB);
        cycle("store",     1'b0, 1'b1, 16'h0042, 16'h0043, 4'd9, 1'b0, 1'b0, 1'b0, 4'd9, 4'd1, 16'h1212, 16'h3434);

        for (int i = 0; i < 24; i++) begin
            cycle("random", 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end

        // Halt followed by a write to R7: neither writes, halt retires once, then frozen.
        cycle("haltEntry", 1'b0, 1'b1, 16'h0001, 16'h0002, 4'd6, 1'b1, 1'b1, 1'b0, 4'd6, 4'd6, 16'h6666, 16'h6767);
        cycle("afterHalt", 1'b0, 1'b1, 16'h7777, 16'h0000, 4'd7, 1'b0, 1'b1, 1'b0, 4'd7, 4'd7, 16'h7070, 16'h0707);
        for (int i = 0; i < 10; i++) begin
            cycle("frozen", 1'b0, 1'b1, 16'($urandom), 16'($urandom), 4'd8, 1'b0, 1'b1, 1'b0,
                  4'd8, 4'd7, 16'h8888, 16'h0808);
        end
        cycle("resetHalted1", 1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 16'h0101, 16'h0202);

        // Drive past 65535 retirements to reach and hold saturation.
        for (int i = 0; i < 65540; i++) begin
            cycle("preload", 1'b0, 1'b1, 16'(i), 16'h0000, 4'd1, 1'b0, 1'b0, 1'b0,
                  4'd2, 4'd3, 16'h0C0C, 16'h0D0D);
        end
        cycle("satHalt",  1'b0, 1'b1, 16'h0000, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2, 16'h1010, 16'h2020);
        cycle("satFrozen", 1'b0, 1'b1, 16'h3333, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 16'h3030, 16'h4040);
        cycle("satFrozen", 1'b0, 1'b1, 16'h3333, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 16'h3030, 16'h4040);
        cycle("resetHalted2", 1'b1, 1'b1, 16'h9999, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0, 4'd4, 4'd4, 16'h5050, 16'h6060);
        cycle("postReset", 1'b0, 1'b1, 16'h4321, 16'h0000, 4'd4, 1'b0, 1'b1, 1'b0, 4'd4, 4'd1, 16'h5050, 16'h6060);
        cycle("postReset2", 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd1, 16'h5050, 16'h6060);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
